// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue side of the ALU datapath. A command (opcode + two operands) taken on
// the cmd_* valid/ready port is registered onto A/B/ALUCntl and held there
// while the external combinational ALU settles. After SETTLE_CYCLES cycles the
// ALU result and its N/Z flags are captured into a small result FIFO, which
// the consumer drains through the res_* valid/ready port.
//
// Parameters
//   SETTLE_CYCLES  cycles ALU inputs are held before sampling (1..15)
//   RES_DEPTH      result FIFO entries (power of two, >= 2)
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   cmd_valid/ready     command handshake; cmd_op/cmd_a/cmd_b are the payload
//   A, B, ALUCntl       registered operands and opcode driven to the ALU
//   ALUout, C, Z, N, V  ALU result and flags (C and V are ignored)
//   res_valid/ready     result handshake for the FIFO head
//   res_data            head result (0 when FIFO is empty)
//   res_flags           head flags {N,Z,C,V} with C,V forced to 0
//   res_err             head entry came from an illegal opcode
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned RES_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  // ALU interface
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUCntl,
  input  logic [31:0] ALUout,
  input  logic        C,
  input  logic        Z,
  input  logic        N,
  input  logic        V,
  // result port
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic        res_err
);

  localparam int unsigned       PTR_W       = $clog2(RES_DEPTH);
  localparam int unsigned       CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(RES_DEPTH);
  localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_SETTLE
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;   // {N,Z,C,V}
    logic        err;
  } res_entry_t;

  // Opcodes the ALU implements; everything else is reported as an error entry
  // but still driven to the ALU with the same timing.
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
      4'b1100, 4'b0111, 4'b1101, 4'b1010: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [3:0]         cnt_q,    cnt_d;
  logic [31:0]        a_q,      a_d;
  logic [31:0]        b_q,      b_d;
  logic [3:0]         op_q,     op_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  res_entry_t         mem_q [RES_DEPTH];

  logic               push;
  logic               pop;
  res_entry_t         push_entry;
  res_entry_t         head;

  // C and V are not trustworthy from this ALU and are never forwarded.
  logic               unused_cv;
  assign unused_cv = C ^ V;

  assign A       = a_q;
  assign B       = b_q;
  assign ALUCntl = op_q;

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cmd_ready = 1'b0;
    push      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only IDLE accepts, and only with a free slot, so the push at the end
        // of SETTLE can never overflow the FIFO.
        cmd_ready = !rst && (count_q < DEPTH_C);
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          cnt_d   = SETTLE_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (is_legal(op_q)) begin
      push_entry = '{data: ALUout, flags: {N, Z, 2'b00}, err: 1'b0};
    end else begin
      push_entry = '{data: 32'h0, flags: 4'h0, err: 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO bookkeeping
  // ---------------------------------------------------------------------------
  assign res_valid = (count_q != '0);
  assign pop       = res_valid && res_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 4'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointers
  // and count empties the FIFO, and res_* are masked while it is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign res_data  = res_valid ? head.data  : 32'h0;
  assign res_flags = res_valid ? head.flags : 4'h0;
  assign res_err   = res_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. A behavioural ALU closes the loop from
// A/B/ALUCntl back to ALUout/N/Z (C/V driven X). Expected result entries are
// queued when a command is accepted and compared as the consumer pops them.
// A second instance with SETTLE_CYCLES=3 covers the mid-SETTLE reset case.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance with SETTLE_CYCLES = 1
  logic        rst, cmd_valid, cmd_ready, res_valid, res_ready, res_err;
  logic [3:0]  cmd_op, alu_cntl, res_flags;
  logic [31:0] cmd_a, cmd_b, a_out, b_out, alu_out, res_data;
  logic        n_f, z_f, c_f, v_f;

  // instance with SETTLE_CYCLES = 3
  logic        rst3, cmd_valid3, cmd_ready3, res_valid3, res_ready3, res_err3;
  logic [3:0]  cmd_op3, alu_cntl3, res_flags3;
  logic [31:0] cmd_a3, cmd_b3, a_out3, b_out3, alu_out3, res_data3;
  logic        n_f3, z_f3;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  assign c_f = 1'bx;
  assign v_f = 1'bx;

  alu_op_sequencer #(.SETTLE_CYCLES(1), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(a_out), .B(b_out), .ALUCntl(alu_cntl), .ALUout(alu_out),
    .C(c_f), .Z(z_f), .N(n_f), .V(v_f),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_err(res_err)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3), .RES_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst3),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .A(a_out3), .B(b_out3), .ALUCntl(alu_cntl3), .ALUout(alu_out3),
    .C(c_f), .Z(z_f3), .N(n_f3), .V(v_f),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_flags(res_flags3), .res_err(res_err3)
  );

  // Behavioural ALU; illegal opcodes produce a non-zero, negative value so a
  // leak into the result entry would be visible.
  function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'b0000:          return a & b;
      4'b0001:          return a | b;
      4'b0011:          return a ^ b;
      4'b0010, 4'b1010: return a + b;
      4'b0110:          return a - b;
      4'b1100:          return ~(a | b);
      4'b0111:          return ~a;
      4'b1101:          return a << 1;
      default:          return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_out  = alu_model(alu_cntl, a_out, b_out);
    n_f      = alu_out[31];
    z_f      = (alu_out == 32'h0);
    alu_out3 = alu_model(alu_cntl3, a_out3, b_out3);
    n_f3     = alu_out3[31];
    z_f3     = (alu_out3 == 32'h0);
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every popped head against the oldest expectation.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(res_valid), 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("res_data",  res_data,         e_mon.data);
        check("res_flags", 32'(res_flags),   32'(e_mon.flags));
        check("res_err",   32'(res_err),     32'(e_mon.err));
      end
    end
  end

  // Present a command, wait (bounded) for cmd_ready, record the expectation,
  // and return in the cycle right after the accepting edge.
  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, exp_t e, string tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) break;
      tick();
    end
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    exp_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send3(logic [3:0] op, logic [31:0] a, logic [31:0] b, string tag);
    cmd_valid3 = 1'b1;
    cmd_op3    = op;
    cmd_a3     = a;
    cmd_b3     = b;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready3) break;
      tick();
    end
    check({tag, "_ready"}, 32'(cmd_ready3), 32'd1);
    tick();
    cmd_valid3 = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    tick();
    check({tag, "_empty"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;  cmd_valid = 1'b1;  res_ready = 1'b1;
    cmd_op = 4'b0010;  cmd_a = 32'hFFFF_FFFF;  cmd_b = 32'h1;
    rst3 = 1'b1; cmd_valid3 = 1'b0; res_ready3 = 1'b0;
    cmd_op3 = 4'h0;  cmd_a3 = 32'h0;  cmd_b3 = 32'h0;

    // 1: reset held two cycles with a command pending
    tick();
    check("rst1_ready", 32'(cmd_ready), 32'd0);
    check("rst1_valid", 32'(res_valid), 32'd0);
    check("rst1_A",     a_out,          32'h0);
    check("rst1_cntl",  32'(alu_cntl),  32'h0);
    tick();
    check("rst2_ready", 32'(cmd_ready), 32'd0);
    check("rst2_A",     a_out,          32'h0);
    check("rst2_data",  res_data,       32'h0);
    check("rst2_flags", 32'(res_flags), 32'h0);
    check("rst2_err",   32'(res_err),   32'h0);
    rst  = 1'b0;
    rst3 = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 2: ADD wraps to zero, Z set; result visible two cycles after accept
    send(4'b0010, 32'hFFFF_FFFF, 32'h1, '{32'h0, 4'b0100, 1'b0}, "add");
    check("add_A",       a_out,          32'hFFFF_FFFF);
    check("add_cntl",    32'(alu_cntl),  32'h2);
    check("add_lat_k1",  32'(res_valid), 32'd0);
    tick();
    check("add_lat_k2",  32'(res_valid), 32'd1);
    tick();
    check("add_single",  32'(res_valid), 32'd0);

    // 3: fill the FIFO with the consumer stalled, 5th command must wait
    res_ready = 1'b0;
    send(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 4'b1000, 1'b0}, "and");
    send(4'b0111, 32'h0,         32'h0,         '{32'hFFFF_FFFF, 4'b1000, 1'b0}, "not");
    send(4'b1101, 32'h8000_0001, 32'h0,         '{32'h0000_0002, 4'b0000, 1'b0}, "sll");
    send(4'b0110, 32'h5,         32'h7,         '{32'hFFFF_FFFE, 4'b1000, 1'b0}, "sub");
    cmd_valid = 1'b1;  cmd_op = 4'b0011;  cmd_a = 32'hAAAA_AAAA;  cmd_b = 32'h5555_5555;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("full_stall_ready", 32'(cmd_ready), 32'd0);
      check("full_hold_A",      a_out,          32'h5);
      check("full_hold_cntl",   32'(alu_cntl),  32'h6);
      check("full_head",        res_data,       32'hF000_F000);
      tick();
    end
    res_ready = 1'b1;
    send(4'b0011, 32'hAAAA_AAAA, 32'h5555_5555, '{32'hFFFF_FFFF, 4'b1000, 1'b0}, "xor");
    drain("t3");

    // 4: illegal opcode takes the legal latency and yields an error entry
    send(4'b1111, 32'h7, 32'h7, '{32'h0, 4'h0, 1'b1}, "ill");
    check("ill_cntl",   32'(alu_cntl),  32'hF);
    check("ill_lat_k1", 32'(res_valid), 32'd0);
    tick();
    check("ill_lat_k2", 32'(res_valid), 32'd1);
    tick();
    check("ill_single", 32'(res_valid), 32'd0);

    // 5: push and pop on the same edge with one entry queued
    res_ready = 1'b0;
    send(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, '{32'h0F0F_00F0, 4'b0000, 1'b0}, "or");
    tick();
    check("sim_one_entry", 32'(res_valid), 32'd1);
    send(4'b1010, 32'd10, 32'd20, '{32'd30, 4'b0000, 1'b0}, "add2");
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("sim_valid",    32'(res_valid), 32'd1);
    check("sim_new_head", res_data,       32'd30);
    tick();
    check("sim_still_one", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("sim_count_one", 32'(res_valid), 32'd0);
    check("sim_drained",   32'(exp_q.size()), 32'd0);

    // 6: SETTLE_CYCLES=3 latency, then reset mid-SETTLE with two entries queued
    send3(4'b0010, 32'd1, 32'd2, "s3_a");
    for (int i = 0; i < 3; i++) begin
      check("s3_lat_wait", 32'(res_valid3), 32'd0);
      tick();
    end
    check("s3_lat_valid", 32'(res_valid3), 32'd1);
    check("s3_lat_data",  res_data3,       32'd3);
    send3(4'b0010, 32'd3, 32'd4, "s3_b");
    send3(4'b0110, 32'd9, 32'd4, "s3_c");
    tick();
    check("s3_pre_rst_head", res_data3, 32'd3);
    rst3 = 1'b1;
    tick();
    check("s3_rst_ready", 32'(cmd_ready3), 32'd0);
    check("s3_rst_valid", 32'(res_valid3), 32'd0);
    check("s3_rst_A",     a_out3,          32'h0);
    check("s3_rst_cntl",  32'(alu_cntl3),  32'h0);
    rst3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s3_no_stale", 32'(res_valid3), 32'd0);
    end
    send3(4'b0011, 32'hAAAA_AAAA, 32'h5555_5555, "s3_x");
    tick(); tick(); tick();
    check("s3_new_valid", 32'(res_valid3), 32'd1);
    check("s3_new_data",  res_data3,       32'hFFFF_FFFF);
    check("s3_new_flags", 32'(res_flags3), 32'h8);
    check("s3_new_err",   32'(res_err3),   32'd0);
    res_ready3 = 1'b1;
    tick();
    res_ready3 = 1'b0;
    check("s3_new_popped", 32'(res_valid3), 32'd0);

    check("final_scoreboard", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
